uart_rx_ctrl: RTL

Controller wrapped around the UART receiver. It holds the receiver configuration (prescale, parity enable, parity type) and applies host changes only when the serial line is idle, so no frame is corrupted mid-reception. It buffers received bytes in a small FIFO with a valid/ready host interface and tracks overrun losses. It sits between the host/register side and the UART_RX datapath.

---
 rtl/uart_rx_ctrl_pkg.sv | 22 ++
 rtl/uart_rx_ctrl_fifo.sv | 54 +++++
 rtl/uart_rx_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the UART receiver controller.
// Optional feature macro used by the top: UART_RX_CTRL_FLUSH_ON_CFG_EN.
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_WAIT_IDLE = 2'd1,
        ST_APPLY     = 2'd2,
        ST_SETTLE    = 2'd3
    } state_e;

    localparam logic [4:0] RST_PRESCALE = 5'd7;
    localparam logic       RST_PAR_EN   = 1'b1;
    localparam logic       RST_PAR_TYPE = 1'b0;
    localparam int         FRAME_LEN    = 11;

    // Oversampling ticks spanning one full frame at the given prescale.
    function automatic logic [15:0] frame_ticks(input logic [4:0] prescale);
        return 16'(FRAME_LEN) * (16'(prescale) + 16'd1);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// First-word-fall-through byte FIFO with push, pop and flush.
module uart_rx_ctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    input  logic       flush_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: idle-gated reconfiguration, byte FIFO, overrun tracking.
// Define UART_RX_CTRL_FLUSH_ON_CFG_EN to discard buffered bytes when a new config is applied.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2,
    parameter int CNT_W      = 8,
    parameter int IDLE_W     = 9
) (
    input  logic             UartRxCtrl_CLK,
    input  logic             UartRxCtrl_RST,
    input  logic             UartRxCtrl_Cfg_Wr,
    input  logic [4:0]       UartRxCtrl_Cfg_Prescale,
    input  logic             UartRxCtrl_Cfg_Par_En,
    input  logic             UartRxCtrl_Cfg_Par_Type,
    output logic             UartRxCtrl_Cfg_Busy,
    input  logic             UartRxCtrl_RX_IN,
    input  logic [7:0]       UartRxCtrl_Rx_PDATA,
    input  logic             UartRxCtrl_Rx_Data_Valid,
    output logic [4:0]       UartRxCtrl_Rx_Prescale,
    output logic             UartRxCtrl_Rx_Par_En,
    output logic             UartRxCtrl_Rx_Par_Type,
    output logic             UartRxCtrl_Rx_RST,
    output logic [7:0]       UartRxCtrl_Dout,
    output logic             UartRxCtrl_Dout_Valid,
    input  logic             UartRxCtrl_Dout_Ready,
    input  logic             UartRxCtrl_Ovr_Clr,
    output logic             UartRxCtrl_Overrun,
    output logic [CNT_W-1:0] UartRxCtrl_Drop_Cnt
);

    state_e            state_q, state_d;
    logic [4:0]        pend_prescale_q, rx_prescale_q;
    logic              pend_par_en_q, rx_par_en_q;
    logic              pend_par_type_q, rx_par_type_q;
    logic              rx_rst_q, cfg_busy_q;
    logic [IDLE_W-1:0] idle_cnt_q, idle_thr;
    logic              line_idle;
    logic              dv_prev_q, push_req;
    logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty, drop;
    logic              overrun_q;
    logic [CNT_W-1:0]  drop_cnt_q;
    logic              cfg_accept;

    assign idle_thr   = IDLE_W'(frame_ticks(rx_prescale_q));
    assign line_idle  = (idle_cnt_q == idle_thr);
    assign cfg_accept = UartRxCtrl_Cfg_Wr && (state_q == ST_RUN || state_q == ST_WAIT_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:       if (UartRxCtrl_Cfg_Wr) state_d = ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (!UartRxCtrl_Cfg_Wr && line_idle) state_d = ST_APPLY;
            ST_APPLY:     state_d = ST_SETTLE;
            default:      state_d = ST_RUN;
        endcase
    end

    // Outputs are derived from the next state so they line up with state_q.
    always_ff @(posedge UartRxCtrl_CLK) begin
        if (UartRxCtrl_RST) begin
            state_q         <= ST_RUN;
            pend_prescale_q <= RST_PRESCALE;
            pend_par_en_q   <= RST_PAR_EN;
            pend_par_type_q <= RST_PAR_TYPE;
            rx_prescale_q   <= RST_PRESCALE;
            rx_par_en_q     <= RST_PAR_EN;
            rx_par_type_q   <= RST_PAR_TYPE;
            rx_rst_q        <= 1'b0;
            cfg_busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (cfg_accept) begin
                pend_prescale_q <= UartRxCtrl_Cfg_Prescale;
                pend_par_en_q   <= UartRxCtrl_Cfg_Par_En;
                pend_par_type_q <= UartRxCtrl_Cfg_Par_Type;
            end
            if (state_q == ST_APPLY) begin
                rx_prescale_q <= pend_prescale_q;
                rx_par_en_q   <= pend_par_en_q;
                rx_par_type_q <= pend_par_type_q;
            end
            rx_rst_q   <= (state_d == ST_RUN) || (state_d == ST_WAIT_IDLE);
            cfg_busy_q <= (state_d != ST_RUN);
        end
    end

    // Counts consecutive high line samples; saturates at one frame length.
    always_ff @(posedge UartRxCtrl_CLK) begin
        if (UartRxCtrl_RST) begin
            idle_cnt_q <= '0;
        end else if (state_q == ST_APPLY || !UartRxCtrl_RX_IN) begin
            idle_cnt_q <= '0;
        end else if (idle_cnt_q < idle_thr) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
        end
    end

    assign push_req = UartRxCtrl_Rx_Data_Valid && !dv_prev_q &&
                      (state_q != ST_APPLY) && (state_q != ST_SETTLE);
    assign fifo_pop  = UartRxCtrl_Dout_Ready && !fifo_empty;
    assign fifo_push = push_req && (!fifo_full || fifo_pop);
    assign drop      = push_req && fifo_full && !fifo_pop;

`ifdef UART_RX_CTRL_FLUSH_ON_CFG_EN
    assign fifo_flush = (state_q == ST_APPLY);
`else
    assign fifo_flush = 1'b0;
`endif

    // A drop in the same cycle as a clear leaves a count of exactly one.
    always_ff @(posedge UartRxCtrl_CLK) begin
        if (UartRxCtrl_RST) begin
            dv_prev_q  <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            dv_prev_q <= UartRxCtrl_Rx_Data_Valid;
            if (drop) begin
                overrun_q <= 1'b1;
                if (UartRxCtrl_Ovr_Clr) begin
                    drop_cnt_q <= CNT_W'(1);
                end else if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end else if (UartRxCtrl_Ovr_Clr) begin
                overrun_q  <= 1'b0;
                drop_cnt_q <= '0;
            end
        end
    end

    uart_rx_ctrl_fifo #(
        .DEPTH (FIFO_DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk_i   (UartRxCtrl_CLK),
        .rst_i   (UartRxCtrl_RST),
        .push_i  (fifo_push),
        .data_i  (UartRxCtrl_Rx_PDATA),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .dout_o  (UartRxCtrl_Dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign UartRxCtrl_Cfg_Busy    = cfg_busy_q;
    assign UartRxCtrl_Rx_Prescale = rx_prescale_q;
    assign UartRxCtrl_Rx_Par_En   = rx_par_en_q;
    assign UartRxCtrl_Rx_Par_Type = rx_par_type_q;
    assign UartRxCtrl_Rx_RST      = rx_rst_q;
    assign UartRxCtrl_Dout_Valid  = !fifo_empty;
    assign UartRxCtrl_Overrun     = overrun_q;
    assign UartRxCtrl_Drop_Cnt    = drop_cnt_q;

endmodule
